net_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one GPU's 16-bit network transmit link between N_REQ local packet sources (AXI-side agents, test generator, DMA).
- Each winner's {dest, payload} is packed into one flit and held in a registered output stage driving net_data_out/net_valid_out.
- Sits between the GPU's internal requesters and the network interface; the NI's net_ready_in is the only backpressure.

---
 rtl/net_tx_arbiter_pkg.sv | 17 +
 rtl/net_tx_arbiter_if.sv | 26 ++
 rtl/net_tx_arbiter_rr_arbiter.sv | 29 ++
 rtl/net_tx_arbiter.sv | 62 ++++++
 tb/tb_net_tx_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/net_tx_arbiter_pkg.sv
// net_tx_arbiter_pkg: shared flit layout, ID constants and output-stage state for the network TX path.
package net_tx_arbiter_pkg;
  localparam int FLIT_W = 16;
  localparam int DEST_W = 6;
  localparam int PAYLOAD_W = 10;
  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_MSB = PAYLOAD_W - 1;
  localparam int DEST_LSB = PAYLOAD_W;
  localparam int DEST_MSB = FLIT_W - 1;
  localparam logic [DEST_W-1:0] BCAST_ID = '1;
  localparam logic [DEST_W-1:0] RESERVED_ID = '0;
  typedef enum logic {EMPTY, FULL} stage_t;
  typedef logic [FLIT_W-1:0] flit_t;
  function automatic flit_t make_flit(input logic [DEST_W-1:0] dest, input logic [PAYLOAD_W-1:0] payload);
    return {dest, payload};
  endfunction
endpackage

// File: rtl/net_tx_arbiter_if.sv
// net_tx_arbiter_if: requester bundle, network-side flit handshake and status counters.
interface net_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DEST_W = 6,
  parameter int PAYLOAD_W = 10
);
  import net_tx_arbiter_pkg::*;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*DEST_W-1:0] req_dest;
  logic [N_REQ*PAYLOAD_W-1:0] req_payload;
  logic [N_REQ-1:0] req_ready;
  logic [FLIT_W-1:0] net_data_out;
  logic net_valid_out;
  logic net_ready_in;
  logic [15:0] drop_count;
  logic [15:0] sent_count;
  logic [$clog2(N_REQ)-1:0] last_grant;
  modport master (
    output req_valid, req_dest, req_payload, net_ready_in,
    input req_ready, net_data_out, net_valid_out, drop_count, sent_count, last_grant
  );
  modport slave (
    input req_valid, req_dest, req_payload, net_ready_in,
    output req_ready, net_data_out, net_valid_out, drop_count, sent_count, last_grant
  );
endinterface

// File: rtl/net_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from i_ptr+1 and wrapping.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  input  logic         i_en,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  logic [W-1:0] w_j;
  // Walk from the farthest offset down so the nearest requester after i_ptr wins last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = W'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = w_j;
      end
    end
    if (o_any && i_en) o_gnt[o_idx] = 1'b1;
  end
endmodule

// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter: round-robin share of the 16-bit network TX link with a one-flit registered output stage.
module net_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int DEST_W = 6,
  parameter int PAYLOAD_W = 10,
  parameter int GPU_ID = 26
) (
  input logic ACLK,
  input logic ARESETn,
  net_tx_arbiter_if.slave bus
);
  import net_tx_arbiter_pkg::*;
  localparam int W = $clog2(N_REQ);
  stage_t r_state, w_state_nxt;
  logic [FLIT_W-1:0] r_data;
  logic [15:0] r_drop, r_sent;
  logic [W-1:0] r_last, w_idx;
  logic [N_REQ-1:0] w_gnt;
  logic [DEST_W-1:0] w_dest;
  logic [PAYLOAD_W-1:0] w_payload;
  logic w_any, w_slot_free, w_accept, w_self, w_depart;
  if (DEST_W + PAYLOAD_W != FLIT_W) begin : g_width_chk
    $error("net_tx_arbiter: DEST_W + PAYLOAD_W must equal FLIT_W");
  end
  assign w_depart = r_state == FULL && bus.net_ready_in;
  assign w_slot_free = r_state == EMPTY || bus.net_ready_in;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_req(bus.req_valid),
    .i_ptr(r_last),
    .i_en(w_slot_free && ARESETn),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign w_accept = w_any && w_slot_free;
  assign w_dest = bus.req_dest[w_idx*DEST_W +: DEST_W];
  assign w_payload = bus.req_payload[w_idx*PAYLOAD_W +: PAYLOAD_W];
  assign w_self = w_dest == DEST_W'(GPU_ID);
  // A self-addressed accept never fills the stage, but a departing flit still leaves.
  always_comb w_state_nxt = (w_accept && !w_self) ? FULL : w_depart ? EMPTY : r_state;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= EMPTY;
      r_data <= '0;
      r_drop <= '0;
      r_sent <= '0;
      r_last <= W'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_last <= w_idx;
      if (w_accept && !w_self) r_data <= {w_dest, w_payload};
      if (w_accept && w_self && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      if (w_depart) r_sent <= r_sent + 16'd1;
    end
  end
  assign bus.req_ready = w_gnt;
  assign bus.net_data_out = r_data;
  assign bus.net_valid_out = r_state == FULL;
  assign bus.drop_count = r_drop;
  assign bus.sent_count = r_sent;
  assign bus.last_grant = r_last;
endmodule

// File: tb/tb_net_tx_arbiter.sv
// tb_net_tx_arbiter: directed stimulus with a flit scoreboard drained by an independent output monitor.
`timescale 1ns/1ps
module tb_net_tx_arbiter;
  import net_tx_arbiter_pkg::*;
  logic clk = 1'b0;
  logic ARESETn;
  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  net_tx_arbiter_if #(.N_REQ(4), .DEST_W(6), .PAYLOAD_W(10)) bus ();
  net_tx_arbiter #(.N_REQ(4), .DEST_W(6), .PAYLOAD_W(10), .GPU_ID(26)) dut (
    .ACLK(clk),
    .ARESETn(ARESETn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [5:0] d, input logic [9:0] p);
    bus.req_valid[i] = 1'b1;
    bus.req_dest[i*6 +: 6] = d;
    bus.req_payload[i*10 +: 10] = p;
  endtask
  always @(negedge clk) begin
    if (ARESETn && bus.net_valid_out && bus.net_ready_in) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit actual=%0h expected=none", bus.net_data_out);
      end else begin
        chk("flit", bus.net_data_out, sb.pop_front());
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    ARESETn = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_dest = '0;
    bus.req_payload = '0;
    bus.net_ready_in = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus.net_valid_out, 0);
    chk("rst_data", bus.net_data_out, 0);
    chk("rst_drop", bus.drop_count, 0);
    chk("rst_sent", bus.sent_count, 0);
    chk("rst_last", bus.last_grant, 3);
    chk("rst_ready", bus.req_ready, 0);
    tick();
    ARESETn = 1'b1;
    bus.req_valid = '0;
    set_req(1, 6'd27, 10'h123);
    @(negedge clk);
    chk("single_ready", bus.req_ready, 4'b0010);
    sb.push_back(16'h6D23);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_valid", bus.net_valid_out, 1);
    chk("single_data", bus.net_data_out, 16'h6D23);
    chk("single_last", bus.last_grant, 1);
    tick();
    @(negedge clk);
    chk("single_sent", bus.sent_count, 1);
    chk("single_empty", bus.net_valid_out, 0);
    tick();
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) set_req(i, 6'(i + 1), 10'(c * 4 + i));
      @(negedge clk);
      chk("rr_ready", bus.req_ready, 4'b0001 << (c % 4));
      if (c > 0) chk("rr_nobubble", bus.net_valid_out, 1);
      sb.push_back(make_flit(6'(c % 4 + 1), 10'(c * 4 + c % 4)));
      tick();
    end
    bus.req_valid = '0;
    @(negedge clk);
    chk("rr_tail_valid", bus.net_valid_out, 1);
    tick();
    @(negedge clk);
    chk("rr_sent", bus.sent_count, 8);
    chk("rr_empty", bus.net_valid_out, 0);
    tick();
    set_req(2, 6'd9, 10'h2B2);
    bus.net_ready_in = 1'b0;
    @(negedge clk);
    chk("bp_ready2", bus.req_ready, 4'b0100);
    sb.push_back(16'h26B2);
    tick();
    bus.req_valid = '0;
    set_req(0, 6'd12, 10'h0C0);
    set_req(3, 6'd13, 10'h0D0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_ready_off", bus.req_ready, 0);
      chk("bp_hold", bus.net_data_out, 16'h26B2);
      chk("bp_valid", bus.net_valid_out, 1);
      tick();
    end
    bus.net_ready_in = 1'b1;
    @(negedge clk);
    chk("bp_ready3", bus.req_ready, 4'b1000);
    sb.push_back(16'h34D0);
    tick();
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    chk("bp_ready0", bus.req_ready, 4'b0001);
    sb.push_back(16'h30C0);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("bp_sent", bus.sent_count, 11);
    tick();
    set_req(0, 6'd26, 10'h055);
    @(negedge clk);
    chk("self_ready", bus.req_ready, 4'b0001);
    tick();
    @(negedge clk);
    chk("self_valid", bus.net_valid_out, 0);
    chk("self_drop1", bus.drop_count, 1);
    repeat (65533) tick();
    @(negedge clk);
    chk("self_drop_fffe", bus.drop_count, 16'hFFFE);
    tick();
    @(negedge clk);
    chk("self_drop_ffff", bus.drop_count, 16'hFFFF);
    repeat (5) tick();
    @(negedge clk);
    chk("self_drop_sat", bus.drop_count, 16'hFFFF);
    chk("self_valid_end", bus.net_valid_out, 0);
    chk("self_last", bus.last_grant, 0);
    tick();
    bus.req_valid = '0;
    set_req(1, 6'd5, 10'h2AA);
    @(negedge clk);
    chk("sim_ready_a", bus.req_ready, 4'b0010);
    sb.push_back(16'h16AA);
    tick();
    set_req(1, 6'd5, 10'h155);
    @(negedge clk);
    chk("sim_ready_b", bus.req_ready, 4'b0010);
    chk("sim_valid_a", bus.net_valid_out, 1);
    sb.push_back(16'h1555);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("sim_valid_b", bus.net_valid_out, 1);
    tick();
    @(negedge clk);
    chk("sim_empty", bus.net_valid_out, 0);
    chk("sim_sent", bus.sent_count, 13);
    tick();
    set_req(2, 6'd7, 10'h3FF);
    bus.net_ready_in = 1'b0;
    @(negedge clk);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("mid_valid", bus.net_valid_out, 1);
    chk("mid_data", bus.net_data_out, 16'h1FFF);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_valid", bus.net_valid_out, 0);
    chk("mid_rst_data", bus.net_data_out, 0);
    chk("mid_rst_sent", bus.sent_count, 0);
    chk("mid_rst_drop", bus.drop_count, 0);
    chk("mid_rst_last", bus.last_grant, 3);
    tick();
    ARESETn = 1'b1;
    bus.net_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 6'(i + 1), 10'(10'h300 + i));
    @(negedge clk);
    chk("post_rst_ready", bus.req_ready, 4'b0001);
    sb.push_back(make_flit(6'd1, 10'h300));
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("post_rst_sent", bus.sent_count, 1);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
